// File: rtl/reg_file_sb.sv
// reg_file_sb: 2-read / 2-write register file with a load scoreboard.
// Ports: clk, rst_n; rd0/rd1 addr->data; wa_* (ALU) and wb_* (load) writes;
//        sb_set/sb_addr mark loads pending; busy0/busy1/stall; pend_cnt.
module reg_file_sb #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] rd0_addr,
  input  logic [ADDR_W-1:0] rd1_addr,
  output logic [DATA_W-1:0] rd0_data,
  output logic [DATA_W-1:0] rd1_data,
  input  logic              wa_en,
  input  logic [ADDR_W-1:0] wa_addr,
  input  logic [DATA_W-1:0] wa_data,
  input  logic              wb_en,
  input  logic [ADDR_W-1:0] wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  input  logic              sb_set,
  input  logic [ADDR_W-1:0] sb_addr,
  output logic              busy0,
  output logic              busy1,
  output logic              stall,
  output logic [ADDR_W:0]   pend_cnt
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam bit ZR    = (ZERO_REG != 0);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DEPTH-1:0]  busy;
  logic [DEPTH-1:0]  busy_nxt;

  logic wa_z, wb_z, sb_z;
  logic wa_ok, wb_ok, sb_ok;
  logic inc, dec;

  assign wa_z  = ZR && (wa_addr == '0);
  assign wb_z  = ZR && (wb_addr == '0);
  assign sb_z  = ZR && (sb_addr == '0);
  assign wa_ok = wa_en && !wa_z;
  assign wb_ok = wb_en && !wb_z;
  assign sb_ok = sb_set && !sb_z;

  // Set is applied after clear so a new load issued in the same
  // cycle as the previous one's writeback stays outstanding.
  always_comb begin
    busy_nxt = busy;
    if (wb_ok) busy_nxt[wb_addr] = 1'b0;
    if (sb_ok) busy_nxt[sb_addr] = 1'b1;
  end

  // Counter deltas: a set only counts if the bit was clear; a clear
  // only counts if the bit was set and is not immediately re-set.
  assign inc = sb_ok && !busy[sb_addr];
  assign dec = wb_ok && busy[wb_addr]
            && !(sb_ok && (sb_addr == wb_addr));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      // Port A is written last so it wins a same-address collision.
      if (wb_ok) mem[wb_addr] <= wb_data;
      if (wa_ok) mem[wa_addr] <= wa_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy     <= '0;
      pend_cnt <= '0;
    end else begin
      busy <= busy_nxt;
      unique case ({inc, dec})
        2'b10:   pend_cnt <= pend_cnt + (ADDR_W+1)'(1);
        2'b01:   pend_cnt <= pend_cnt - (ADDR_W+1)'(1);
        default: pend_cnt <= pend_cnt;
      endcase
    end
  end

  logic [ADDR_W-1:0] ra [2];
  logic [DATA_W-1:0] rdat [2];
  logic [1:0]        rbusy;

  assign ra[0] = rd0_addr;
  assign ra[1] = rd1_addr;

  always_comb begin
    for (int p = 0; p < 2; p++) begin
      rdat[p]  = mem[ra[p]];
      rbusy[p] = busy[ra[p]]
              && !(wb_en && (wb_addr == ra[p]));
      if (ZR && (ra[p] == '0)) begin
        rdat[p]  = '0;
        rbusy[p] = 1'b0;
      end else if (wa_en && (wa_addr == ra[p])) begin
        rdat[p] = wa_data;
      end else if (wb_en && (wb_addr == ra[p])) begin
        rdat[p] = wb_data;
      end
    end
  end

  assign rd0_data = rdat[0];
  assign rd1_data = rdat[1];
  assign busy0    = rbusy[0];
  assign busy1    = rbusy[1];
  assign stall    = rbusy[0] | rbusy[1];

endmodule

// File: tb/tb_reg_file_sb.sv
// tb_reg_file_sb: directed test of reg_file_sb with a scoreboard queue
// drained by a negedge monitor.
module tb_reg_file_sb;

  localparam int DW = 32;
  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [AW-1:0] rd0_addr, rd1_addr;
  logic [DW-1:0] rd0_data, rd1_data;
  logic          wa_en, wb_en, sb_set;
  logic [AW-1:0] wa_addr, wb_addr, sb_addr;
  logic [DW-1:0] wa_data, wb_data;
  logic          busy0, busy1, stall;
  logic [AW:0]   pend_cnt;

  reg_file_sb #(.DATA_W(DW), .ADDR_W(AW), .ZERO_REG(1)) dut (
    .clk(clk), .rst_n(rst_n),
    .rd0_addr(rd0_addr), .rd1_addr(rd1_addr),
    .rd0_data(rd0_data), .rd1_data(rd1_data),
    .wa_en(wa_en), .wa_addr(wa_addr), .wa_data(wa_data),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .sb_set(sb_set), .sb_addr(sb_addr),
    .busy0(busy0), .busy1(busy1), .stall(stall),
    .pend_cnt(pend_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    string         name;
    int            sel;
    logic [DW-1:0] val;
  } exp_t;

  exp_t q[$];
  int   checks   = 0;
  int   failures = 0;

  localparam int S_RD0 = 0, S_RD1 = 1, S_B0 = 2;
  localparam int S_B1 = 3, S_ST = 4, S_PC = 5;

  function automatic logic [DW-1:0] observe(int sel);
    case (sel)
      S_RD0:   return rd0_data;
      S_RD1:   return rd1_data;
      S_B0:    return DW'(busy0);
      S_B1:    return DW'(busy1);
      S_ST:    return DW'(stall);
      default: return DW'(pend_cnt);
    endcase
  endfunction

  always @(negedge clk) begin
    while (q.size() > 0) begin
      exp_t e;
      logic [DW-1:0] act;
      e   = q.pop_front();
      act = observe(e.sel);
      checks++;
      if (act !== e.val) begin
        failures++;
        $display("FAIL %s: got 0x%08h expected 0x%08h",
                 e.name, act, e.val);
      end
    end
  end

  task automatic expect_v(string n, int sel, logic [DW-1:0] v);
    exp_t e;
    e.name = n; e.sel = sel; e.val = v;
    q.push_back(e);
  endtask

  task automatic next_cycle();
    @(posedge clk); #1;
    wa_en = 0; wb_en = 0; sb_set = 0;
    wa_addr = 0; wb_addr = 0; sb_addr = 0;
    wa_data = 0; wb_data = 0;
  endtask

  task automatic wa(int a, logic [DW-1:0] d);
    wa_en = 1; wa_addr = AW'(a); wa_data = d;
  endtask

  task automatic wb(int a, logic [DW-1:0] d);
    wb_en = 1; wb_addr = AW'(a); wb_data = d;
  endtask

  task automatic sb(int a);
    sb_set = 1; sb_addr = AW'(a);
  endtask

  initial begin
    rst_n = 0;
    rd0_addr = 0; rd1_addr = 0;
    wa_en = 0; wb_en = 0; sb_set = 0;
    wa_addr = 0; wb_addr = 0; sb_addr = 0;
    wa_data = 0; wb_data = 0;

    // in reset: write and sb_set must be ignored
    next_cycle();
    wa(9, 32'hDEAD_BEEF); sb(9);
    rd0_addr = 5;
    expect_v("rst_rd0", S_RD0, 0);
    expect_v("rst_pend", S_PC, 0);
    expect_v("rst_stall", S_ST, 0);

    next_cycle();
    rst_n = 1;
    wa(5, 32'h0000_1234);
    rd0_addr = 5; rd1_addr = 9;
    expect_v("wa_bypass", S_RD0, 32'h0000_1234);
    expect_v("rst_wr_ign", S_RD1, 0);
    expect_v("rst_sb_ign", S_PC, 0);

    next_cycle();
    rd0_addr = 5;
    expect_v("wa_r5", S_RD0, 32'h0000_1234);

    next_cycle();
    wa(7, 32'hAAAA_AAAA); wb(7, 32'h5555_5555);
    rd0_addr = 7; rd1_addr = 7;
    expect_v("byp_a_pri0", S_RD0, 32'hAAAA_AAAA);
    expect_v("byp_a_pri1", S_RD1, 32'hAAAA_AAAA);

    next_cycle();
    wb(8, 32'h0000_0077);
    rd0_addr = 7; rd1_addr = 8;
    expect_v("a_wins_r7", S_RD0, 32'hAAAA_AAAA);
    expect_v("wb_bypass", S_RD1, 32'h0000_0077);

    next_cycle();
    wa(0, 32'hFFFF_FFFF); wb(0, 32'hFFFF_FFFF); sb(0);
    rd0_addr = 0; rd1_addr = 8;
    expect_v("r0_byp", S_RD0, 0);
    expect_v("r0_busy_byp", S_B0, 0);
    expect_v("wb_r8", S_RD1, 32'h0000_0077);

    next_cycle();
    rd0_addr = 0;
    expect_v("r0_zero", S_RD0, 0);
    expect_v("r0_busy", S_B0, 0);
    expect_v("r0_pend", S_PC, 0);

    next_cycle();
    sb(3);
    rd1_addr = 3;
    expect_v("sb3_pre", S_B1, 0);

    next_cycle();
    rd1_addr = 3;
    expect_v("sb3_busy1", S_B1, 1);
    expect_v("sb3_stall", S_ST, 1);
    expect_v("sb3_pend", S_PC, 1);

    next_cycle();
    wb(3, 32'h0000_00FF);
    rd1_addr = 3;
    expect_v("wb3_busy1", S_B1, 0);
    expect_v("wb3_stall", S_ST, 0);
    expect_v("wb3_data", S_RD1, 32'h0000_00FF);
    expect_v("wb3_pend_pre", S_PC, 1);

    next_cycle();
    rd1_addr = 3;
    expect_v("wb3_pend", S_PC, 0);
    expect_v("wb3_rd", S_RD1, 32'h0000_00FF);

    next_cycle();
    sb(4);

    next_cycle();
    sb(4); wb(4, 32'h0000_0044);
    rd0_addr = 4;
    expect_v("sbwb4_busy0", S_B0, 0);
    expect_v("sbwb4_rd0", S_RD0, 32'h0000_0044);
    expect_v("sbwb4_pend_pre", S_PC, 1);

    next_cycle();
    rd0_addr = 4;
    expect_v("sbwb4_busy", S_B0, 1);
    expect_v("sbwb4_pend", S_PC, 1);
    expect_v("sbwb4_data", S_RD0, 32'h0000_0044);

    next_cycle();
    sb(4);

    next_cycle();
    wa(4, 32'h0000_0099);
    rd0_addr = 4;
    expect_v("nest_pend", S_PC, 1);
    expect_v("wa4_byp", S_RD0, 32'h0000_0099);
    expect_v("wa4_busy", S_B0, 1);

    next_cycle();
    rd0_addr = 4;
    expect_v("wa_noclr", S_B0, 1);
    expect_v("wa_noclr_pc", S_PC, 1);

    next_cycle();
    wb(4, 32'h0000_0045); wa(6, 32'h0000_0066);
    sb(12);

    next_cycle();
    rd0_addr = 4; rd1_addr = 6;
    expect_v("dual_wb4", S_RD0, 32'h0000_0045);
    expect_v("dual_wa6", S_RD1, 32'h0000_0066);
    expect_v("set_clr_pc", S_PC, 1);

    for (int i = 1; i < 32; i++) begin
      next_cycle();
      wa(i, DW'(i) * 32'h0101_0101);
      if (i == 10 || i == 11) sb(i);
    end

    next_cycle();
    rd0_addr = 10; rd1_addr = 31;
    expect_v("load_r31", S_RD1, 32'h1F1F_1F1F);
    expect_v("load_pend", S_PC, 3);
    expect_v("load_stall", S_ST, 1);

    next_cycle();
    rst_n = 0;
    rd0_addr = 10; rd1_addr = 31;
    expect_v("arst_rd0", S_RD0, 0);
    expect_v("arst_rd1", S_RD1, 0);
    expect_v("arst_busy0", S_B0, 0);
    expect_v("arst_stall", S_ST, 0);
    expect_v("arst_pend", S_PC, 0);

    next_cycle();
    rst_n = 1;
    rd0_addr = 12; rd1_addr = 31;
    expect_v("post_rst_b0", S_B0, 0);
    expect_v("post_rst_r31", S_RD1, 0);
    expect_v("post_rst_pc", S_PC, 0);

    for (int k = 0; k < 20 && q.size() > 0; k++) @(posedge clk);
    @(posedge clk);
    if (q.size() != 0) begin
      failures++;
      $display("FAIL drain: got %0d pending expected 0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
